// File: rtl/spike_router_pkg.sv
// Shared widths and the column lookup-table entry type for the spike route scheduler.
package spike_router_pkg;

    localparam int SPIKE_ADDR_W = 6;
    localparam int DROP_CNT_W   = 16;
    localparam int MAX_ROW_W    = 8;

    typedef struct packed {
        logic                    en;
        logic [MAX_ROW_W-1:0]    row;
        logic [SPIKE_ADDR_W-1:0] addr;
    } spike_lut_entry_t;

endpackage

// File: rtl/spike_in_if.sv
// Single-row spike port: valid strobe plus synapse address, no backpressure.
interface spike_in_if;
    logic                                    valid;
    logic [spike_router_pkg::SPIKE_ADDR_W-1:0] address;

    modport master (output valid, output address);
    modport slave  (input valid, input address);
endinterface

// File: rtl/system_if.sv
// Clock and synchronous active-low reset bundle.
interface system_if;
    logic clk;
    logic reset;

    modport nn (input clk, input reset);
endinterface

// File: rtl/spike_rr_arbiter.sv
// Combinational round-robin find-first: first set req bit at or above ptr, wrapping to 0.
module spike_rr_arbiter #(
    parameter  int N = 1,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx
);

    always_comb begin
        int unsigned j;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!grant_valid && req[j]) begin
                grant_valid = 1'b1;
                grant_idx   = W'(j);
            end
        end
    end

endmodule

// File: rtl/spike_route_scheduler.sv
// Routes pending column spikes round-robin onto synapse rows; external stimulus wins its row.
// Optional: define SPIKE_ROUTER_DROP_COUNT_EN to build the saturating drop counter.
module spike_route_scheduler
    import spike_router_pkg::*;
#(
    parameter  int NUM_COLS         = 1,
    parameter  int NUM_SYNAPSE_ROWS = 1,
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1,
    localparam int ROW_W = (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1
) (
    system_if.nn                  sys_if,
    input  logic [NUM_COLS-1:0]   spike_input,
    spike_in_if.slave             external_stimulus [NUM_SYNAPSE_ROWS],
    spike_in_if.master            spike_output      [NUM_SYNAPSE_ROWS],
    input  logic                  cfg_we,
    input  logic [COL_W-1:0]      cfg_col,
    input  logic                  cfg_en,
    input  logic [ROW_W-1:0]      cfg_row,
    input  logic [SPIKE_ADDR_W-1:0] cfg_addr,
    output logic                  busy,
    output logic [DROP_CNT_W-1:0] drop_count
);

    logic clk;
    logic rst_n;
    assign clk   = sys_if.clk;
    assign rst_n = sys_if.reset;

    logic [NUM_COLS-1:0]         pending;
    logic [COL_W-1:0]            rr_ptr;
    spike_lut_entry_t            lut [NUM_COLS];

    logic [NUM_SYNAPSE_ROWS-1:0] ext_valid;
    logic [SPIKE_ADDR_W-1:0]     ext_addr  [NUM_SYNAPSE_ROWS];
    logic [NUM_SYNAPSE_ROWS-1:0] out_valid;
    logic [SPIKE_ADDR_W-1:0]     out_addr  [NUM_SYNAPSE_ROWS];

    for (genvar r = 0; r < NUM_SYNAPSE_ROWS; r++) begin : g_row
        assign ext_valid[r]            = external_stimulus[r].valid;
        assign ext_addr[r]             = external_stimulus[r].address;
        assign spike_output[r].valid   = out_valid[r];
        assign spike_output[r].address = out_addr[r];
    end

    logic             grant_valid;
    logic [COL_W-1:0] grant_idx;

    spike_rr_arbiter #(.N(NUM_COLS)) u_arb (
        .req         (pending),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    spike_lut_entry_t    grant_entry;
    logic [ROW_W-1:0]    grant_row;
    logic                served;
    logic                issue;
    logic [NUM_COLS-1:0] served_mask;
    logic [COL_W-1:0]    ptr_next;
    logic                col_ok;
    logic                row_ok;
    logic                cfg_ok;

    // Range guards collapse to constants when the count fills its index width.
    if (NUM_COLS == (1 << COL_W)) begin : g_col_full
        assign col_ok = 1'b1;
    end else begin : g_col_part
        assign col_ok = cfg_col < COL_W'(NUM_COLS);
    end
    if (NUM_SYNAPSE_ROWS == (1 << ROW_W)) begin : g_row_full
        assign row_ok = 1'b1;
    end else begin : g_row_part
        assign row_ok = cfg_row < ROW_W'(NUM_SYNAPSE_ROWS);
    end

    always_comb begin
        grant_entry = lut[grant_idx];
        grant_row   = grant_entry.row[ROW_W-1:0];
        issue       = grant_valid && grant_entry.en && !ext_valid[grant_row];
        served      = grant_valid && (!grant_entry.en || !ext_valid[grant_row]);
        served_mask = '0;
        if (served) served_mask[grant_idx] = 1'b1;
        ptr_next    = (grant_idx == COL_W'(NUM_COLS - 1)) ? '0 : grant_idx + 1'b1;
        cfg_ok      = cfg_we && col_ok && row_ok;
    end

    assign busy = |pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
            rr_ptr  <= '0;
            for (int unsigned c = 0; c < NUM_COLS; c++) lut[c] <= '0;
        end else begin
            pending <= (pending & ~served_mask) | spike_input;
            if (served) rr_ptr <= ptr_next;
            if (cfg_ok) begin
                lut[cfg_col].en   <= cfg_en;
                lut[cfg_col].row  <= MAX_ROW_W'(cfg_row);
                lut[cfg_col].addr <= cfg_addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            for (int unsigned r = 0; r < NUM_SYNAPSE_ROWS; r++) out_addr[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
                if (ext_valid[r]) begin
                    out_valid[r] <= 1'b1;
                    out_addr[r]  <= ext_addr[r];
                end else if (issue && grant_entry.row == MAX_ROW_W'(r)) begin
                    out_valid[r] <= 1'b1;
                    out_addr[r]  <= grant_entry.addr;
                end else begin
                    out_valid[r] <= 1'b0;
                    out_addr[r]  <= '0;
                end
            end
        end
    end

`ifdef SPIKE_ROUTER_DROP_COUNT_EN
    logic [NUM_COLS-1:0]   drop_vec;
    logic [DROP_CNT_W:0]   drop_sum;
    logic [DROP_CNT_W-1:0] drop_cnt;

    always_comb begin
        drop_vec = spike_input & pending & ~served_mask;
        drop_sum = {1'b0, drop_cnt} + (DROP_CNT_W + 1)'($countones(drop_vec));
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                drop_cnt <= '0;
        else if (drop_sum[DROP_CNT_W]) drop_cnt <= '1;
        else                       drop_cnt <= drop_sum[DROP_CNT_W-1:0];
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = '0;
`endif

endmodule

// File: tb/tb_spike_route_scheduler.sv
// Randomized and directed bench for spike_route_scheduler against a cycle-level reference model.
module tb_spike_route_scheduler;
    import spike_router_pkg::*;

    localparam int NC = 4;
    localparam int NR = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    system_if   sys_if ();
    spike_in_if ext [NR] ();
    spike_in_if out [NR] ();

    assign sys_if.clk   = clk;
    assign sys_if.reset = rst_n;

    logic [NR-1:0]           ext_v;
    logic [SPIKE_ADDR_W-1:0] ext_a [NR];
    logic [NR-1:0]           out_v;
    logic [SPIKE_ADDR_W-1:0] out_a [NR];

    for (genvar r = 0; r < NR; r++) begin : g_rows
        assign ext[r].valid   = ext_v[r];
        assign ext[r].address = ext_a[r];
        assign out_v[r]       = out[r].valid;
        assign out_a[r]       = out[r].address;
    end

    logic [NC-1:0]           spike_in;
    logic                    cfg_we, cfg_en;
    logic [1:0]              cfg_col, cfg_row;
    logic [SPIKE_ADDR_W-1:0] cfg_addr;
    logic                    busy;
    logic [DROP_CNT_W-1:0]   drop_count;

    spike_route_scheduler #(.NUM_COLS(NC), .NUM_SYNAPSE_ROWS(NR)) dut (
        .sys_if            (sys_if),
        .spike_input       (spike_in),
        .external_stimulus (ext),
        .spike_output      (out),
        .cfg_we            (cfg_we),
        .cfg_col           (cfg_col),
        .cfg_en            (cfg_en),
        .cfg_row           (cfg_row),
        .cfg_addr          (cfg_addr),
        .busy              (busy),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit m_pend [NC];
    int m_ptr;
    bit m_en   [NC];
    int m_row  [NC];
    int m_addr [NC];
    int m_drop;
    bit m_ov   [NR];
    int m_oa   [NR];

    task automatic model_step();
        int  g;
        bit  gv, served, issue;
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                m_pend[c] = 0; m_en[c] = 0; m_row[c] = 0; m_addr[c] = 0;
            end
            m_ptr = 0; m_drop = 0;
            for (int r = 0; r < NR; r++) begin m_ov[r] = 0; m_oa[r] = 0; end
            return;
        end
        gv = 0; g = 0;
        for (int i = 0; i < NC; i++) begin
            int c = (m_ptr + i) % NC;
            if (!gv && m_pend[c]) begin gv = 1; g = c; end
        end
        served = 0; issue = 0;
        if (gv) begin
            if (!m_en[g]) served = 1;
            else if (!ext_v[m_row[g]]) begin served = 1; issue = 1; end
        end
        for (int r = 0; r < NR; r++) begin
            if (ext_v[r]) begin m_ov[r] = 1; m_oa[r] = ext_a[r]; end
            else if (issue && m_row[g] == r) begin m_ov[r] = 1; m_oa[r] = m_addr[g]; end
            else begin m_ov[r] = 0; m_oa[r] = 0; end
        end
        for (int c = 0; c < NC; c++) begin
            if (served && c == g) m_pend[c] = spike_in[c];
            else begin
                if (spike_in[c] && m_pend[c] && m_drop < 65535) m_drop++;
                m_pend[c] = m_pend[c] | spike_in[c];
            end
        end
        if (served) m_ptr = (g + 1) % NC;
        if (cfg_we && cfg_col < NC && cfg_row < NR) begin
            m_en[cfg_col] = cfg_en; m_row[cfg_col] = cfg_row; m_addr[cfg_col] = cfg_addr;
        end
    endtask

    task automatic step(input string ph);
        int exp_drop;
        bit exp_busy;
        model_step();
        @(posedge clk);
        #1;
        exp_busy = 0;
        for (int c = 0; c < NC; c++) exp_busy |= m_pend[c];
`ifdef SPIKE_ROUTER_DROP_COUNT_EN
        exp_drop = m_drop;
`else
        exp_drop = 0;
`endif
        for (int r = 0; r < NR; r++) begin
            check($sformatf("%s valid[%0d]", ph, r), 32'(out_v[r]), 32'(m_ov[r]));
            check($sformatf("%s addr[%0d]", ph, r), 32'(out_a[r]), m_oa[r]);
        end
        check($sformatf("%s busy", ph), 32'(busy), 32'(exp_busy));
        check($sformatf("%s drop_count", ph), 32'(drop_count), exp_drop);
    endtask

    task automatic idle_inputs();
        spike_in = '0; ext_v = '0; cfg_we = 0; cfg_en = 0;
        cfg_col = '0; cfg_row = '0; cfg_addr = '0;
        for (int r = 0; r < NR; r++) ext_a[r] = '0;
    endtask

    task automatic prog(input int col, input bit en, input int row, input int addr);
        cfg_we = 1; cfg_col = 2'(col); cfg_en = en; cfg_row = 2'(row); cfg_addr = 6'(addr);
        step("cfg");
        cfg_we = 0;
    endtask

    task automatic do_reset();
        rst_n = 0; step("rst"); rst_n = 1;
    endtask

    initial begin
        int rr_row [NC];
        int cnt;
        rr_row = '{0, 1, 2, 0};
        idle_inputs();

        // Reset held with activity on every input
        rst_n = 0; spike_in = '1; ext_v = '1;
        for (int r = 0; r < NR; r++) ext_a[r] = 6'($urandom);
        for (int i = 0; i < 3; i++) begin
            step("reset");
            check("reset out_v", 32'(out_v), 0);
            check("reset busy", 32'(busy), 0);
        end
        rst_n = 1; idle_inputs();
        spike_in = 4'b0101; step("post-reset"); spike_in = '0;
        for (int i = 0; i < 3; i++) begin
            step("post-reset");
            check("lut disabled out_v", 32'(out_v), 0);
        end

        // Single route
        prog(2, 1, 1, 'h15);
        spike_in = 4'b0100; step("route"); spike_in = '0;
        check("route t+1 valid", 32'(out_v[1]), 0);
        step("route");
        check("route t+2 valid", 32'(out_v[1]), 1);
        check("route t+2 addr", 32'(out_a[1]), 'h15);
        step("route");
        check("route t+3 valid", 32'(out_v[1]), 0);

        // Collision with external stimulus
        prog(0, 1, 0, 'h2A);
        spike_in = 4'b0001; step("coll");
        spike_in = '0; ext_v[0] = 1; ext_a[0] = 6'h03; step("coll");
        check("coll t+2 ext", 32'({out_v[0], out_a[0]}), 32'({1'b1, 6'h03}));
        step("coll");
        check("coll t+3 ext", 32'({out_v[0], out_a[0]}), 32'({1'b1, 6'h03}));
        ext_v[0] = 0; ext_a[0] = '0; step("coll");
        check("coll t+4 net", 32'({out_v[0], out_a[0]}), 32'({1'b1, 6'h2A}));
        step("coll");

        // Round-robin from a known pointer
        do_reset();
        for (int c = 0; c < NC; c++) prog(c, 1, rr_row[c], 'h10 + c);
        spike_in = '1; step("rr"); spike_in = '0;
        for (int c = 0; c < NC; c++) begin
            step("rr");
            check($sformatf("rr order col%0d valid", c), 32'(out_v[rr_row[c]]), 1);
            check($sformatf("rr order col%0d addr", c), 32'(out_a[rr_row[c]]), 'h10 + c);
        end
        spike_in = 4'b1010; step("rr2"); spike_in = '0;
        step("rr2");
        check("rr2 first col1", 32'({out_v[1], out_a[1]}), 32'({1'b1, 6'h11}));
        step("rr2");
        check("rr2 second col3", 32'({out_v[0], out_a[0]}), 32'({1'b1, 6'h13}));
        step("rr2");

        // Overflow while stalled by continuous stimulus
        ext_v[1] = 1; ext_a[1] = 6'h22;
        for (int i = 0; i < 3; i++) begin spike_in = 4'b0010; step("ovf"); end
        spike_in = '0; step("ovf"); step("ovf");
        ext_v[1] = 0; ext_a[1] = '0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step("ovf");
            if (out_v[1] && out_a[1] == 6'h11) cnt++;
        end
        check("ovf single output", cnt, 1);
`ifdef SPIKE_ROUTER_DROP_COUNT_EN
        check("ovf drop_count", 32'(drop_count), 2);
`else
        check("ovf drop_count", 32'(drop_count), 0);
`endif

        // Pulse arriving in the cycle its column is served
        spike_in = 4'b0100; step("same"); step("same"); spike_in = '0;
        cnt = (out_v[2] && out_a[2] == 6'h12) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            step("same");
            if (out_v[2] && out_a[2] == 6'h12) cnt++;
        end
        check("same-cycle pulse outputs", cnt, 2);

        // Out-of-range row write is ignored
        prog(0, 1, NR, 'h3F);
        spike_in = 4'b0001; step("badrow"); spike_in = '0;
        step("badrow");
        check("badrow old entry", 32'({out_v[0], out_a[0]}), 32'({1'b1, 6'h10}));
        step("badrow");

`ifdef SPIKE_ROUTER_DROP_COUNT_EN
        // Counter saturation: every row blocked, every column re-pulsed each cycle
        ext_v = '1; spike_in = '1;
        for (int i = 0; i < 16400; i++) step("sat");
        check("drop saturates", 32'(drop_count), 'hFFFF);
        idle_inputs(); step("sat");
`endif

        // Randomized traffic
        idle_inputs();
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            spike_in = NC'($urandom) & NC'($urandom);
            for (int r = 0; r < NR; r++) begin
                ext_v[r] = ($urandom_range(0, 5) == 0);
                ext_a[r] = ext_v[r] ? 6'($urandom) : 6'h0;
            end
            cfg_we   = ($urandom_range(0, 7) == 0);
            cfg_col  = 2'($urandom);
            cfg_row  = 2'($urandom);
            cfg_en   = ($urandom_range(0, 3) != 0);
            cfg_addr = 6'($urandom);
            step("rand");
        end
        rst_n = 1; idle_inputs();
        for (int i = 0; i < 8; i++) step("drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spike_route_scheduler.md
# spike_route_scheduler

Scheduler that turns neuron column spikes into synapse-row spike events and shares each row's spike port between external stimulus and network-generated spikes. Pending column spikes are served round-robin, one per cycle, through a configurable column→(row, address) lookup table. External stimulus always has priority on its row; a colliding network spike is held until the row is free. The block sits between the neural network's `spike_input` bus and the synapse-row `spike_in_if` array, and replaces the pass-through router.

## Interface
Parameters:
- `NUM_COLS`, 1: number of neuron columns driving `spike_input`.
- `NUM_SYNAPSE_ROWS`, 1: number of synapse rows, equal to the number of `spike_output` and `external_stimulus` interfaces.

Ports:
- `sys_if`, `system_if.nn`, -, provides `clk` and `reset`. One clock. Reset is synchronous and active-low.
- `spike_input`, in, `[NUM_COLS]` × 1: one-cycle spike pulse per column.
- `external_stimulus`, `spike_in_if.slave`, `[NUM_SYNAPSE_ROWS]`: `valid` and `address` from the stimulus source. This interface has no backpressure.
- `spike_output`, `spike_in_if.master`, `[NUM_SYNAPSE_ROWS]`: registered `valid` and `address` to the synapse rows.
- `cfg_we`, in, 1: LUT write strobe.
- `cfg_col`, in, COL_W: LUT index to write.
- `cfg_en`, in, 1: enables routing for that column.
- `cfg_row`, in, ROW_W: target row.
- `cfg_addr`, in, SPIKE_ADDR_W: address emitted on the target row.
- `busy`, out, 1: high while any pending bit is set.
- `drop_count`, out, 16: count of spikes lost to overflow.

## Operation
- **Reset values:** `pending` = 0, `rr_ptr` = 0, and every LUT entry is {en=0, row=0, addr=0}. All `spike_output[r].valid` and `.address` are 0, `busy` = 0 and `drop_count` = 0.
- **Pending capture:** each cycle, `pending[c]` is set by `spike_input[c]` and cleared when column c is served or discarded.
- **Overflow:** if `spike_input[c]` arrives while `pending[c]` is set and c is not served that cycle, the spike is dropped and `drop_count` increments, saturating at 0xFFFF. If c is served in the same cycle the pulse arrives, `pending[c]` stays set and nothing is dropped.
- **Selection:** each cycle the grant is the first set `pending` bit at or above `rr_ptr`, wrapping from `NUM_COLS-1` to 0. The LUT entry for the granted column then decides the action:
  - `en`=0: clear `pending[g]`, emit nothing, advance `rr_ptr`.
  - `en`=1 and `external_stimulus[row].valid` is high this cycle: stall. `pending[g]` and `rr_ptr` are held.
  - `en`=1 and the row is free: register `valid`=1 and `address`=`addr` on `spike_output[row]`, clear `pending[g]`, and set `rr_ptr` = g+1 mod NUM_COLS.
- **Throughput:** at most one network spike is issued per cycle in total.
- **External stimulus:** `spike_output[r]` registers `external_stimulus[r]` whenever the input `valid` is 1. The scheduler's conflict check guarantees it never collides with a network spike on the same row.
- **Idle output:** when neither source drives a row, `valid` = 0 and `address` holds 0.
- **LUT writes:** take effect at the clock edge. A lookup in the same cycle as a write to the same column uses the old entry. Writes with `cfg_col` ≥ NUM_COLS or `cfg_row` ≥ NUM_SYNAPSE_ROWS are ignored.
- **Reset mid-operation:** clears pending spikes, the LUT and the counter. Spikes in flight are lost and are not counted as drops.

## Timing
- External stimulus: latency 1 cycle. Valid in cycle t appears on `spike_output` in cycle t+1.
- Network spike: `spike_input` in cycle t sets `pending` in cycle t+1. If the spike is granted and its row is free in t+1, it appears on `spike_output` in t+2.
- Each cycle of stall or lost arbitration adds exactly 1 cycle of latency.
- Worst-case service: with all columns pending and no conflicts, column c waits at most `NUM_COLS-1` cycles.
- `busy` is combinational from `pending`. `drop_count` updates at the edge after the dropped pulse.
- Widths:
  - COL_W = NUM_COLS>1 ? $clog2(NUM_COLS) : 1.
  - ROW_W = NUM_SYNAPSE_ROWS>1 ? $clog2(NUM_SYNAPSE_ROWS) : 1.
  - `rr_ptr` wraps modulo NUM_COLS, not modulo 2^COL_W.

## Configuration
- `SPIKE_ROUTER_DROP_COUNT_EN`:
  - Defined: the saturating 16-bit drop counter is implemented.
  - Undefined: `drop_count` is tied to 0 and no counter logic exists. Drop behaviour itself is unchanged.

## Structure
- Package `spike_router_pkg` holds:
  - `SPIKE_ADDR_W` = 6, matching `spike_in_if`.
  - `DROP_CNT_W` = 16.
  - Typedef `spike_lut_entry_t` as a packed struct {en, row, addr}, where the `row` field is sized to the maximum supported row count.
- Sub-module `spike_rr_arbiter`:
  - Parameter `N`.
  - Inputs `req[N]` and `ptr`.
  - Outputs `grant_valid` and `grant_idx`.
  - Purely combinational find-first from `ptr` with wrap.
- The top level holds `pending`, `rr_ptr`, the LUT, the output registers and the counter.

## Test plan
- **Reset:** hold `reset` low for 3 cycles with `spike_input` and stimulus active. All outputs stay 0 and `busy` = 0. After release, all LUT entries read as disabled, so a spike produces no output.
- **Single route:** program col 2 → row 1, addr 0x15. Pulse col 2 at cycle t. Expect `spike_output[1]` to show valid=1, address=0x15 in t+2 only.
- **Collision:** col 0 is routed to row 0. Pulse col 0 at t and drive `external_stimulus[0]` valid in t+1 and t+2 with addr 0x3. Expect the external spike in t+2 and t+3, and the network spike in t+4.
- **Round-robin:** NUM_COLS=4, all enabled, pulse all columns at t. Expect outputs in t+2..t+5 in order col 0,1,2,3. Then, with `rr_ptr`=0, pulse cols 3 and 1. Expect col 1 first, then col 3.
- **Overflow:** with col 1 stalled by continuous stimulus on its row, pulse col 1 three times. Expect `drop_count` = 2 and exactly one output after the stimulus stops.
- **Boundaries:**
  - A pulse on a column in the same cycle that column is served is not dropped.
  - A write with `cfg_row` = NUM_SYNAPSE_ROWS is ignored.
  - `drop_count` saturates at 0xFFFF.
